// File: rtl/integration_button_pio_if.sv
// Avalon-MM slave bus bundle for the button PIO: word address, select, write strobe, data.
interface integration_button_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/integration_button_pio.sv
// Input PIO: synchronises pins, captures selected edges into sticky W1C bits, raises masked irq.
// Optional per-bit debounce filter enabled by defining INTEGRATION_PIO_DEBOUNCE_EN.
module integration_button_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_port,
    integration_button_pio_if.slave   bus,
    output logic                      irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] clear_bits;
    logic             wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef INTEGRATION_PIO_DEBOUNCE_EN
    localparam int unsigned CntW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = (DEBOUNCE_CYCLES < 1) ? '0 : CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [WIDTH-1:0] stable_q;

    // A bit is accepted only after sync2 has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync2[i] != stable_q[i]) begin
                    if (cnt_q[i] == CntLast) begin
                        stable_q[i] <= sync2[i];
                        cnt_q[i]    <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign data_in = stable_q;
`else
    assign data_in = sync2;
`endif

    always_ff @(posedge clk) begin
        if (reset) data_d <= '0;
        else       data_d <= data_in;
    end

    always_comb begin
        edge_event = '0;
        case (EDGE_TYPE)
            0:       edge_event = data_in & ~data_d;
            2:       edge_event = data_in ^ data_d;
            default: edge_event = ~data_in & data_d;
        endcase
    end

    assign wr = bus.chipselect & ~bus.write_n;

    // A new event wins over a same-cycle W1C so no edge is ever lost.
    always_comb begin
        clear_bits = '0;
        mask_d     = mask_q;
        if (wr && bus.address == 2'd3) clear_bits = bus.writedata[WIDTH-1:0];
        if (wr && bus.address == 2'd2) mask_d = bus.writedata[WIDTH-1:0];
        capture_d = edge_event | (capture_q & ~clear_bits);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            capture_q <= '0;
            mask_q    <= '0;
            irq       <= 1'b0;
        end else begin
            capture_q <= capture_d;
            mask_q    <= mask_d;
            irq       <= |(capture_d & mask_d);
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata[WIDTH-1:0] = data_in;
            2'd2:    bus.readdata[WIDTH-1:0] = mask_q;
            2'd3:    bus.readdata[WIDTH-1:0] = capture_q;
            default: bus.readdata = '0;
        endcase
    end

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^bus.writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_integration_button_pio.sv
// Scoreboard bench for integration_button_pio: expectations queued with stimulus, popped on sample.
module tb_integration_button_pio;

    logic       clk;
    logic       reset;
    logic [3:0] in_port;
    logic       irq;

    integration_button_pio_if bus ();

    integration_button_pio #(
        .WIDTH          (4),
        .EDGE_TYPE      (1),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_port(in_port),
        .bus    (bus.slave),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "timeout");
    end

    // Advance one edge and settle just after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus.address    = 2'd0;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = data;
        tick();
        bus_idle();
    endtask

    task automatic test_reset();
        bus_idle();
        in_port = 4'hF;
        reset   = 1'b1;
        tick(3);
        exp_q.push_back(32'h0);
        bus.address = 2'd0;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL reset_data: got %h, expected %h", bus.readdata, exp_v);
        end
        reset = 1'b0;
        tick(3);
        exp_q.push_back(32'h0000000F);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus.address = 2'd0;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL data_after_reset: got %h, expected %h", bus.readdata, exp_v);
        end
        bus.address = 2'd3;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL capture_after_reset: got %h, expected %h", bus.readdata, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'b0, irq} !== exp_v) begin
            failures++;
            $display("FAIL irq_after_reset: got %0d, expected %0d", irq, exp_v);
        end
        bus_idle();
    endtask

    task automatic test_masked_fall();
        bus_write(2'd2, 32'h1);
        exp_q.push_back(32'h1);
        bus.address = 2'd2;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL mask_readback: got %h, expected %h", bus.readdata, exp_v);
        end
        in_port = 4'hE;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        tick(2);
        bus.address = 2'd3;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL capture_early: got %h, expected %h", bus.readdata, exp_v);
        end
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL capture_bit0: got %h, expected %h", bus.readdata, exp_v);
        end
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'b0, irq} !== exp_v) begin
            failures++;
            $display("FAIL irq_bit0: got %0d, expected %0d", irq, exp_v);
        end
        tick(7);
        in_port = 4'hF;
        tick(4);
        exp_q.push_back(32'h1);
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'b0, irq} !== exp_v) begin
            failures++;
            $display("FAIL irq_sticky: got %0d, expected %0d", irq, exp_v);
        end
        bus_write(2'd3, 32'h1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus.address = 2'd3;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL capture_w1c: got %h, expected %h", bus.readdata, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'b0, irq} !== exp_v) begin
            failures++;
            $display("FAIL irq_after_w1c: got %0d, expected %0d", irq, exp_v);
        end
        bus_idle();
    endtask

    task automatic test_unmasked_then_mask();
        bus_write(2'd2, 32'h0);
        in_port = 4'hB;
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h0);
        tick(3);
        bus.address = 2'd3;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL capture_bit2: got %h, expected %h", bus.readdata, exp_v);
        end
        tick(2);
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'b0, irq} !== exp_v) begin
            failures++;
            $display("FAIL irq_unmasked: got %0d, expected %0d", irq, exp_v);
        end
        bus_write(2'd2, 32'h4);
        exp_q.push_back(32'h1);
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'b0, irq} !== exp_v) begin
            failures++;
            $display("FAIL irq_on_mask: got %0d, expected %0d", irq, exp_v);
        end
        bus_write(2'd3, 32'h4);
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'b0, irq} !== exp_v) begin
            failures++;
            $display("FAIL irq_clear_bit2: got %0d, expected %0d", irq, exp_v);
        end
        in_port = 4'hF;
        tick(4);
    endtask

    task automatic test_event_vs_clear();
        in_port = 4'hD;
        tick(2);
        // The event lands on the third edge; the W1C of bit 1 is presented on that same edge.
        bus_write(2'd3, 32'h2);
        exp_q.push_back(32'h2);
        bus.address = 2'd3;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL event_beats_clear: got %h, expected %h", bus.readdata, exp_v);
        end
        in_port = 4'hF;
        tick(4);
        bus_write(2'd3, 32'hF);
        exp_q.push_back(32'h0);
        bus.address = 2'd3;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL capture_cleared: got %h, expected %h", bus.readdata, exp_v);
        end
        bus_idle();
    endtask

`ifdef INTEGRATION_PIO_DEBOUNCE_EN
    task automatic test_debounce();
        in_port = 4'h7;
        tick(5);
        in_port = 4'hF;
        tick(20);
        exp_q.push_back(32'hF);
        exp_q.push_back(32'h0);
        bus.address = 2'd0;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL glitch_data: got %h, expected %h", bus.readdata, exp_v);
        end
        bus.address = 2'd3;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL glitch_capture: got %h, expected %h", bus.readdata, exp_v);
        end
        in_port = 4'h7;
        exp_q.push_back(32'hF);
        exp_q.push_back(32'h7);
        exp_q.push_back(32'h8);
        bus.address = 2'd0;
        tick(9);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL debounce_early: got %h, expected %h", bus.readdata, exp_v);
        end
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL debounce_latency: got %h, expected %h", bus.readdata, exp_v);
        end
        tick();
        bus.address = 2'd3;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL debounce_capture: got %h, expected %h", bus.readdata, exp_v);
        end
        tick(10);
        in_port = 4'hF;
        tick(20);
        bus_write(2'd3, 32'hF);
    endtask
`endif

    task automatic test_mid_reset();
        int lat;
`ifdef INTEGRATION_PIO_DEBOUNCE_EN
        lat = 12;
`else
        lat = 4;
`endif
        bus_write(2'd2, 32'hF);
        in_port = 4'h0;
        tick(lat);
        exp_q.push_back(32'hF);
        exp_q.push_back(32'h1);
        bus.address = 2'd3;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL capture_all: got %h, expected %h", bus.readdata, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'b0, irq} !== exp_v) begin
            failures++;
            $display("FAIL irq_all: got %0d, expected %0d", irq, exp_v);
        end
        reset = 1'b1;
        tick();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'b0, irq} !== exp_v) begin
            failures++;
            $display("FAIL irq_mid_reset: got %0d, expected %0d", irq, exp_v);
        end
        bus.address = 2'd3;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL capture_mid_reset: got %h, expected %h", bus.readdata, exp_v);
        end
        bus.address = 2'd2;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL mask_mid_reset: got %h, expected %h", bus.readdata, exp_v);
        end
        reset = 1'b0;
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_write(2'd0, 32'hFFFF_FFFF);
        tick(lat);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus.address = 2'd1;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL direction_read: got %h, expected %h", bus.readdata, exp_v);
        end
        bus.address = 2'd0;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL data_write_ignored: got %h, expected %h", bus.readdata, exp_v);
        end
        bus.address = 2'd3;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.readdata !== exp_v) begin
            failures++;
            $display("FAIL no_event_on_release: got %h, expected %h", bus.readdata, exp_v);
        end
        bus_idle();
    endtask

    initial begin
        reset   = 1'b1;
        in_port = 4'hF;
        bus_idle();
        test_reset();
        test_masked_fall();
        test_unmasked_then_mask();
        test_event_vs_clear();
`ifdef INTEGRATION_PIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
